// File: rtl/mem_store_rmw_pkg.sv
// Shared encodings for the MEM-stage store read-modify-write path.
// Opcode/funct3 values, FSM states and the store legality check.
package mem_store_rmw_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] FUNCT3_B = 2'b00;
  localparam logic [1:0] FUNCT3_H = 2'b01;
  localparam logic [1:0] FUNCT3_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  function automatic logic store_illegal(
    input logic [2:0] f3,
    input logic [1:0] lane
  );
    logic bad_w, bad_h;
    bad_h = (f3[1:0] == FUNCT3_H) && lane[0];
    bad_w = (f3[1:0] == FUNCT3_W) &&
            (lane != 2'b00);
    return f3[2] || (f3[1:0] == 2'b11) ||
           bad_h || bad_w;
  endfunction

endpackage

// File: rtl/mem_store_rmw_if.sv
// Request handshake between the MEM stage and the store RMW block.
// master = MEM stage, slave = store RMW block.
interface mem_store_rmw_if #(
  parameter int ADDR_W = 32
);

  logic              valid_in;
  logic              ready_out;
  logic [6:0]        opcode_in;
  logic [2:0]        funct3_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       store_data_in;

  modport master (
    output valid_in,
    output opcode_in,
    output funct3_in,
    output addr_in,
    output store_data_in,
    input  ready_out
  );

  modport slave (
    input  valid_in,
    input  opcode_in,
    input  funct3_in,
    input  addr_in,
    input  store_data_in,
    output ready_out
  );

endinterface

// File: rtl/mem_store_rmw_store_merge.sv
// Combinational lane merge of store data into an existing RAM word.
// Byte and half stores replace one lane; word stores replace everything.
module store_merge
  import mem_store_rmw_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [1:0]  width,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    unique case (width)
      FUNCT3_B: new_word[{lane, 3'b000} +: 8] = data[7:0];
      FUNCT3_H: begin
        if (lane[1]) new_word[31:16] = data[15:0];
        else         new_word[15:0]  = data[15:0];
      end
      default:  new_word = data;
    endcase
  end

endmodule

// File: rtl/mem_store_rmw.sv
// Store path to a strobe-less word RAM: SW written directly,
// SB/SH via read, lane merge, write.
module mem_store_rmw
  import mem_store_rmw_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_store_rmw_if.slave    req,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  output logic              done_out,
  output logic              err_out
);

  state_e      state, state_nxt;
  logic [1:0]  lane_q;
  logic [1:0]  width_q;
  logic [31:0] data_q;
  logic [31:0] merged;
  logic        acc;
  logic        bad;
  logic        go;
  logic        is_w;

  assign req.ready_out = (state == ST_IDLE);

  assign acc  = req.valid_in && req.ready_out &&
                (req.opcode_in == OPC_STORE);
  assign bad  = store_illegal(req.funct3_in,
                              req.addr_in[1:0]);
  assign go   = acc && !bad;
  assign is_w = (req.funct3_in[1:0] == FUNCT3_W);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nxt = is_w ? ST_WRITE : ST_READ;
      end
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  store_merge u_merge (
    .old_word (ram_rdata),
    .data     (data_q),
    .lane     (lane_q),
    .width    (width_q),
    .new_word (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      done_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      ram_re   <= (state_nxt == ST_READ);
      ram_we   <= (state_nxt == ST_WRITE);
      done_out <= (state_nxt == ST_WRITE);
      err_out  <= acc && bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      lane_q    <= '0;
      width_q   <= '0;
      data_q    <= '0;
    end else begin
      if (go) begin
        ram_addr <= req.addr_in[ADDR_W-1:2];
        lane_q   <= req.addr_in[1:0];
        width_q  <= req.funct3_in[1:0];
        data_q   <= req.store_data_in;
      end
      if (go && is_w) begin
        ram_wdata <= req.store_data_in;
      end else if (state == ST_WAIT) begin
        ram_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_rmw.sv
// Directed bench for mem_store_rmw with a small word-RAM model.
// Expected values are hand-computed constants.
module tb_mem_store_rmw;
  import mem_store_rmw_pkg::*;

  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        done_out;
  logic        err_out;

  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;
  int          wr_cnt;
  int          both_cnt;
  int          n_cmp;
  int          n_bad;

  mem_store_rmw_if #(.ADDR_W(ADDR_W)) bus ();

  mem_store_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .done_out  (done_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  // RAM returns garbage when not read so stray sampling is visible.
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_we && ram_re) both_cnt <= both_cnt + 1;
    ram_rdata <= ram_re ? mem[ram_addr[7:0]] : 32'h0BAD0BAD;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    bus.valid_in      = 1'b1;
    bus.opcode_in     = op;
    bus.funct3_in     = f3;
    bus.addr_in       = a;
    bus.store_data_in = d;
  endtask

  task automatic drop();
    bus.valid_in = 1'b0;
  endtask

  task automatic do_sw(input string t,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [29:0] wa);
    @(negedge clk);
    chk({t, "_rdy0"}, bus.ready_out, 1);
    issue(OPC_STORE, 3'b010, a, d);
    @(negedge clk);
    drop();
    chk({t, "_we"}, ram_we, 1);
    chk({t, "_addr"}, ram_addr, wa);
    chk({t, "_wd"}, ram_wdata, d);
    chk({t, "_done"}, done_out, 1);
    chk({t, "_re"}, ram_re, 0);
    chk({t, "_busy"}, bus.ready_out, 0);
    @(negedge clk);
    chk({t, "_rdy1"}, bus.ready_out, 1);
    chk({t, "_we0"}, ram_we, 0);
  endtask

  task automatic do_rmw(input string t,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [29:0] wa,
                        input logic [31:0] wd);
    @(negedge clk);
    issue(OPC_STORE, f3, a, d);
    @(negedge clk);
    drop();
    chk({t, "_re"}, ram_re, 1);
    chk({t, "_raddr"}, ram_addr, wa);
    chk({t, "_rdy"}, bus.ready_out, 0);
    @(negedge clk);
    chk({t, "_wait"}, {ram_re, ram_we}, 0);
    @(negedge clk);
    chk({t, "_we"}, ram_we, 1);
    chk({t, "_waddr"}, ram_addr, wa);
    chk({t, "_wd"}, ram_wdata, wd);
    chk({t, "_done"}, done_out, 1);
    @(negedge clk);
    chk({t, "_rdy1"}, bus.ready_out, 1);
    chk({t, "_mem"}, mem[wa[7:0]], wd);
  endtask

  task automatic do_err(input string t,
                        input logic [2:0] f3,
                        input logic [31:0] a);
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    issue(OPC_STORE, f3, a, 32'h55AA55AA);
    @(negedge clk);
    drop();
    chk({t, "_err"}, err_out, 1);
    chk({t, "_rewe"}, {ram_re, ram_we}, 0);
    chk({t, "_rdy"}, bus.ready_out, 1);
    @(negedge clk);
    chk({t, "_err0"}, err_out, 0);
    chk({t, "_rewe1"}, {ram_re, ram_we}, 0);
    chk({t, "_nowr"}, wr_cnt - w0, 0);
  endtask

  initial begin
    int w0;
    n_cmp = 0; n_bad = 0;
    wr_cnt = 0; both_cnt = 0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.opcode_in = '0;
    bus.funct3_in = '0;
    bus.addr_in = '0;
    bus.store_data_in = '0;
    #1;
    chk("rst_re", ram_re, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wd", ram_wdata, 0);
    chk("rst_flags", {done_out, err_out}, 0);
    chk("rst_rdy", bus.ready_out, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_sw("sw", 32'h100, 32'hDEADBEEF, 30'h40);

    preload(8'h40, 32'h11223344);
    do_rmw("sb", 3'b000, 32'h102, 32'h000000AA,
           30'h40, 32'h11AA3344);
    preload(8'h03, 32'h11223344);
    do_rmw("sh", 3'b001, 32'h0E, 32'h0000BEEF,
           30'h03, 32'hBEEF3344);
    preload(8'h04, 32'h11223344);
    do_rmw("sh_lo", 3'b001, 32'h10, 32'h1234CAFE,
           30'h04, 32'h1122CAFE);
    preload(8'h05, 32'h11223344);
    do_rmw("sb3", 3'b000, 32'h17, 32'h000000EE,
           30'h05, 32'hEE223344);

    do_err("sh_mis", 3'b001, 32'h101);
    do_err("sw_mis", 3'b010, 32'h102);
    do_err("f3_100", 3'b100, 32'h100);
    do_err("f3_011", 3'b011, 32'h100);

    // Non-store opcode is ignored entirely.
    w0 = wr_cnt;
    @(negedge clk);
    issue(7'b0000011, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    drop();
    chk("ld_ign", {ram_re, ram_we, err_out}, 0);
    chk("ld_rdy", bus.ready_out, 1);
    @(negedge clk);
    chk("ld_nowr", wr_cnt - w0, 0);

    // SB followed by a held SW.
    preload(8'h50, 32'hA5A5A5A5);
    w0 = wr_cnt;
    @(negedge clk);
    issue(OPC_STORE, 3'b000, 32'h141, 32'h0000003C);
    @(negedge clk);
    chk("b2b_re", ram_re, 1);
    issue(OPC_STORE, 3'b010, 32'h180, 32'hCAFEF00D);
    @(negedge clk);
    chk("b2b_wait", {ram_we, bus.ready_out}, 0);
    @(negedge clk);
    chk("b2b_we1", ram_we, 1);
    chk("b2b_wd1", ram_wdata, 32'hA5A53CA5);
    chk("b2b_a1", ram_addr, 30'h50);
    chk("b2b_busy", bus.ready_out, 0);
    @(negedge clk);
    chk("b2b_gap", ram_we, 0);
    chk("b2b_rdy", bus.ready_out, 1);
    @(negedge clk);
    drop();
    chk("b2b_we2", ram_we, 1);
    chk("b2b_wd2", ram_wdata, 32'hCAFEF00D);
    chk("b2b_a2", ram_addr, 30'h60);
    @(negedge clk);
    chk("b2b_cnt", wr_cnt - w0, 2);
    chk("b2b_m1", mem[8'h50], 32'hA5A53CA5);
    chk("b2b_m2", mem[8'h60], 32'hCAFEF00D);

    // Reset during WAIT of an SB.
    preload(8'h70, 32'h01020304);
    w0 = wr_cnt;
    @(negedge clk);
    issue(OPC_STORE, 3'b000, 32'h1C0, 32'h000000FF);
    @(negedge clk);
    drop();
    chk("ab_re", ram_re, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ab_out", {ram_re, ram_we, done_out, err_out}, 0);
    chk("ab_addr", ram_addr, 0);
    chk("ab_wd", ram_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ab_nowr", wr_cnt - w0, 0);
    chk("ab_mem", mem[8'h70], 32'h01020304);
    do_sw("sw2", 32'h200, 32'h12345678, 30'h80);

    chk("re_we_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
